// File: rtl/apple_iie_video_shifter.sv
// apple_iie_video_shifter: serializes RAM/char-ROM bytes into the 14M pixel stream; SHIFTER_DHIRES_EN adds double hi-res.
module apple_iie_video_shifter #(
  parameter int LORES_ROT_H0 = 2
) (
  input  logic       clk_14M,
  input  logic       rst,
  input  logic       ldps_n,
  input  logic       vid7m,
  input  logic       h0,
  input  logic       segb,
  input  logic       gr,
  input  logic       hires,
  input  logic       eighty_vid_n,
  input  logic       vid7,
  input  logic       blank,
  input  logic [7:0] main_data,
  input  logic [7:0] aux_data,
  output logic       vid_out
);
`ifdef SHIFTER_DHIRES_EN
  typedef enum logic [2:0] {TEXT40, TEXT80, LORES, HIRES, DHIRES} mode_t;
`else
  typedef enum logic [1:0] {TEXT40, TEXT80, LORES, HIRES} mode_t;
`endif
  mode_t mode, mode_in, mode_n;
  logic [13:0] sr, sr_n;
  logic [3:0] nib, nib_n, nib_sel;
  logic [7:0] nib_dbl;
  logic load, wide, dly, dly_n, pipe, pix_n;
  logic unused_aux7;
  assign unused_aux7 = aux_data[7];
  always_comb begin
    load = !ldps_n;
    mode_in = gr ? (hires ? HIRES : LORES) : (eighty_vid_n ? TEXT40 : TEXT80);
`ifdef SHIFTER_DHIRES_EN
    mode_in = (gr && hires && !eighty_vid_n) ? DHIRES : mode_in;
`endif
    mode_n = load ? mode_in : mode;
    wide = mode_n == TEXT80;
`ifdef SHIFTER_DHIRES_EN
    wide = wide || mode_n == DHIRES;
`endif
    nib_sel = segb ? main_data[7:4] : main_data[3:0];
    // rotate right via a doubled nibble so column parity keeps the colour phase
    nib_dbl = {nib_sel, nib_sel} >> (h0 ? LORES_ROT_H0 % 4 : 0);
    nib_n = load ? nib_dbl[3:0] : {nib[0], nib[3:1]};
    sr_n = load ? (wide ? {main_data[6:0], aux_data[6:0]} : {7'd0, main_data[6:0]})
         : (wide || vid7m) ? sr >> 1 : sr;
    pix_n = (mode_n == LORES) ? nib_n[0] : sr_n[0];
    dly_n = load ? (mode_in == HIRES && vid7) : dly;
  end
  always_ff @(posedge clk_14M) begin
    if (rst) begin
      mode <= TEXT40;
      sr <= '0;
      nib <= '0;
      dly <= 1'b0;
      pipe <= 1'b0;
      vid_out <= 1'b0;
    end else begin
      mode <= mode_n;
      sr <= sr_n;
      nib <= nib_n;
      dly <= dly_n;
      pipe <= pix_n;
      vid_out <= !blank && (dly_n ? pipe : pix_n);
    end
  end
endmodule

// File: tb/tb_apple_iie_video_shifter.sv
// tb_apple_iie_video_shifter: table vectors, corner sequences and random stimulus against a pixel-count model.
module tb_apple_iie_video_shifter;
  localparam int ROT = 2;
  logic clk_14M = 0, rst = 1, ldps_n = 1, vid7m = 0, h0 = 0, segb = 0, gr = 0, hires = 0;
  logic eighty_vid_n = 1, vid7 = 0, blank = 0;
  logic [7:0] main_data = 0, aux_data = 0;
  logic vid_out;
  int vectors = 0, errors = 0;
  bit ph = 1;

  apple_iie_video_shifter #(.LORES_ROT_H0(ROT)) dut (
    .clk_14M(clk_14M), .rst(rst), .ldps_n(ldps_n), .vid7m(vid7m), .h0(h0), .segb(segb),
    .gr(gr), .hires(hires), .eighty_vid_n(eighty_vid_n), .vid7(vid7), .blank(blank),
    .main_data(main_data), .aux_data(aux_data), .vid_out(vid_out));

  always #5 clk_14M = ~clk_14M;

  // model: 0 text40, 1 text80, 2 lores, 3 hires, 4 dhires
  int m_mode = 0, m_cnt = 0, m_k = 0, m_rot = 0;
  logic [13:0] m_word = 0;
  logic [3:0] m_nib = 0;
  bit m_dly = 0, m_prev = 0, m_exp = 0;

  task automatic model();
    bit pix;
    if (rst) begin
      m_mode = 0; m_word = 0; m_cnt = 0; m_nib = 0; m_k = 0; m_rot = 0;
      m_dly = 0; m_prev = 0; m_exp = 0;
      return;
    end
    if (!ldps_n) begin
      m_mode = gr ? (hires ? 3 : 2) : (eighty_vid_n ? 0 : 1);
`ifdef SHIFTER_DHIRES_EN
      if (gr && hires && !eighty_vid_n) m_mode = 4;
`endif
      m_word = (m_mode == 1 || m_mode == 4) ? {main_data[6:0], aux_data[6:0]} : {7'd0, main_data[6:0]};
      m_nib = segb ? main_data[7:4] : main_data[3:0];
      m_rot = h0 ? ROT : 0;
      m_cnt = 0; m_k = 0;
      m_dly = (m_mode == 3) && vid7;
    end else begin
      m_k++;
      if ((m_mode == 1 || m_mode == 4 || vid7m) && m_cnt < 14) m_cnt++;
    end
    pix = (m_mode == 2) ? m_nib[(m_k + m_rot) % 4] : (m_cnt < 14 ? m_word[m_cnt] : 1'b0);
    m_exp = blank ? 1'b0 : (m_dly ? m_prev : pix);
    m_prev = pix;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic step();
    vid7m = ph;
    model();
    @(posedge clk_14M);
    ph = ~ph;
    #1;
    chk("cycle", {31'd0, vid_out}, {31'd0, m_exp});
  endtask

  task automatic align();
    if (!ph) step();
  endtask

  task automatic set_mode(logic g, logic hr, logic e80);
    gr = g; hires = hr; eighty_vid_n = e80;
  endtask

  typedef struct {
    logic [7:0] m, a;
    logic g, hr, e80, sg, h, v7;
    logic [15:0] exp;
    string nm;
  } vec_t;
  vec_t tbl[10];
  logic [31:0] s;

  initial begin
    tbl[0] = '{8'h55, 8'h00, 0, 0, 1, 0, 0, 0, 16'h3333, "t40_55"};
    tbl[1] = '{8'h7F, 8'h00, 0, 0, 1, 0, 0, 0, 16'h3FFF, "t40_7f"};
    tbl[2] = '{8'h7F, 8'h00, 0, 0, 0, 0, 0, 0, 16'h3F80, "t80_7f_00"};
    tbl[3] = '{8'h00, 8'h55, 0, 0, 0, 0, 0, 0, 16'h0055, "t80_00_55"};
    tbl[4] = '{8'hA3, 8'h00, 1, 0, 1, 1, 0, 0, 16'hAAAA, "lores_hi_h0"};
    tbl[5] = '{8'hA3, 8'h00, 1, 0, 1, 1, 1, 0, 16'hAAAA, "lores_hi_h1"};
    tbl[6] = '{8'hA3, 8'h00, 1, 0, 1, 0, 0, 0, 16'h3333, "lores_lo_h0"};
    tbl[7] = '{8'hA3, 8'h00, 1, 0, 1, 0, 1, 0, 16'hCCCC, "lores_lo_h1"};
    tbl[8] = '{8'h01, 8'h00, 1, 1, 1, 0, 0, 0, 16'h0003, "hires_01"};
    tbl[9] = '{8'h81, 8'h00, 1, 1, 1, 0, 0, 1, 16'h0006, "hires_81_dly"};

    rst = 1;
    step(); step();
    chk("reset", {31'd0, vid_out}, 32'd0);
    rst = 0;
    step();

    foreach (tbl[j]) begin
      align();
      main_data = tbl[j].m; aux_data = tbl[j].a; set_mode(tbl[j].g, tbl[j].hr, tbl[j].e80);
      segb = tbl[j].sg; h0 = tbl[j].h; vid7 = tbl[j].v7; ldps_n = 0;
      s = '0;
      for (int i = 0; i < 16; i++) begin step(); ldps_n = 1; s[i] = vid_out; end
      chk(tbl[j].nm, s, {16'd0, tbl[j].exp});
    end

    // blank for 4 cycles mid-byte
    align();
    main_data = 8'h7F; set_mode(0, 0, 1); vid7 = 0; ldps_n = 0; s = '0;
    for (int i = 0; i < 16; i++) begin
      blank = (i >= 4 && i < 8);
      step(); ldps_n = 1; s[i] = vid_out;
    end
    blank = 0;
    chk("blank_mid", s, 32'h3F0F);

    // hi-res byte followed by a delayed byte
    align();
    set_mode(1, 1, 1); s = '0;
    for (int i = 0; i < 18; i++) begin
      ldps_n = !(i == 0 || i == 14);
      main_data = (i == 14) ? 8'h81 : 8'h01;
      vid7 = (i == 14);
      step(); s[i] = vid_out;
    end
    ldps_n = 1; vid7 = 0;
    chk("hires_half_px", s, 32'h18003);

    // mode inputs changing mid-column are ignored
    align();
    main_data = 8'h55; set_mode(0, 0, 1); ldps_n = 0; s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin set_mode(1, 1, 0); segb = 1; end
      step(); ldps_n = 1; s[i] = vid_out;
    end
    chk("mode_hold", s, 32'h3333);

    // reset overrides a simultaneous load
    align();
    main_data = 8'hA3; set_mode(1, 0, 1); segb = 1; h0 = 0; ldps_n = 0;
    step(); ldps_n = 1; step(); step();
    rst = 1; ldps_n = 0; main_data = 8'h7F; set_mode(0, 0, 1);
    step();
    chk("reset_load", {31'd0, vid_out}, 32'd0);
    rst = 0; ldps_n = 1; s = '0;
    for (int i = 0; i < 16; i++) begin step(); s[i] = vid_out; end
    chk("reset_discard", s, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      ldps_n = ($urandom_range(11) != 0);
      blank = ($urandom_range(7) == 0);
      {h0, segb, gr, hires, eighty_vid_n, vid7} = 6'($urandom);
      main_data = 8'($urandom); aux_data = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
